// File: rtl/rf_ctrl.sv
// rf_ctrl: sequencer and round-robin arbiter driving the 8-bit register file.
// Optional feature macro: RF_CTRL_SWAP_EN builds SWP (states EX2/EX3, tmp).
// Ports: clk, rst (async active-low); req_valid/req_ready/req_op/req_src/
//   req_dst/req_imm per-port commands; bus_in = rf p; d/d_en bus drive;
//   ie/oe one-hot {F,D,C,B,A}; busy; done per port; err with done.
module rf_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [3:0]  req_op,
    input  logic [5:0]  req_src,
    input  logic [5:0]  req_dst,
    input  logic [15:0] req_imm,
    input  logic [7:0]  bus_in,
    output logic [7:0]  d,
    output logic        d_en,
    output logic [4:0]  ie,
    output logic [4:0]  oe,
    output logic        busy,
    output logic [1:0]  done,
    output logic        err
);
    localparam logic [1:0] OP_NOP = 2'd0;
    localparam logic [1:0] OP_MOV = 2'd1;
    localparam logic [1:0] OP_LDI = 2'd2;
    localparam logic [1:0] OP_SWP = 2'd3;

`ifdef RF_CTRL_SWAP_EN
    typedef enum logic [2:0] {IDLE, EX1, EX2, EX3, FIN} state_t;
`else
    typedef enum logic [1:0] {IDLE, EX1, FIN} state_t;
`endif

    state_t      state, nstate;
    logic [1:0]  op_q;
    logic [2:0]  src_q, dst_q;
    logic [7:0]  imm_q;
    logic        own_q, last_grant;
    logic        win, take, bad;
    logic [1:0]  cop;
    logic [2:0]  csrc, cdst;
    logic [7:0]  cimm;
    logic        cown;
    logic [7:0]  d_n;
    logic        den_n, err_n;
    logic [4:0]  ie_n, oe_n;
    logic [1:0]  done_n;
`ifdef RF_CTRL_SWAP_EN
    logic [7:0]  tmp;
`endif

    function automatic logic [4:0] sel(input logic [2:0] r);
        return 5'b00001 << r;
    endfunction

    function automatic logic badr(input logic [2:0] r);
        return r > 3'd4;
    endfunction

    // Both valid: the port not served last wins.
    always_comb begin
        win = (req_valid == 2'b11) ? ~last_grant : req_valid[1];
        take = (state == IDLE) && (req_valid != 2'b00);
        req_ready = 2'b00;
        if (take) req_ready[win] = 1'b1;
    end

    // In IDLE the winner's live fields are decoded so the first strobes
    // can be registered on the accepting edge itself.
    always_comb begin
        cop  = op_q;
        csrc = src_q;
        cdst = dst_q;
        cimm = imm_q;
        cown = own_q;
        if (state == IDLE) begin
            cop  = win ? req_op[3:2]   : req_op[1:0];
            csrc = win ? req_src[5:3]  : req_src[2:0];
            cdst = win ? req_dst[5:3]  : req_dst[2:0];
            cimm = win ? req_imm[15:8] : req_imm[7:0];
            cown = win;
        end
    end

    always_comb begin
        bad = 1'b0;
        unique case (cop)
            OP_NOP: bad = 1'b0;
            OP_MOV: bad = badr(csrc) | badr(cdst);
            OP_LDI: bad = badr(cdst);
`ifdef RF_CTRL_SWAP_EN
            OP_SWP: bad = badr(csrc) | badr(cdst);
`else
            OP_SWP: bad = 1'b1;
`endif
        endcase
    end

    always_comb begin
        nstate = state;
        d_n    = '0;
        den_n  = 1'b0;
        ie_n   = '0;
        oe_n   = '0;
        done_n = '0;
        err_n  = 1'b0;
        unique case (state)
            IDLE: if (take) begin
                nstate = FIN;
                if (bad) begin
                    err_n = 1'b1;
                end else begin
                    unique case (cop)
                        OP_MOV: if (csrc != cdst) begin
                            nstate = EX1;
                            oe_n = sel(csrc);
                            ie_n = sel(cdst);
                        end
                        OP_LDI: begin
                            nstate = EX1;
                            d_n = cimm;
                            den_n = 1'b1;
                            ie_n = sel(cdst);
                        end
`ifdef RF_CTRL_SWAP_EN
                        OP_SWP: if (csrc != cdst) begin
                            nstate = EX1;
                            oe_n = sel(csrc);
                        end
`endif
                        default: ;
                    endcase
                end
            end
            EX1: begin
                nstate = FIN;
`ifdef RF_CTRL_SWAP_EN
                if (op_q == OP_SWP) begin
                    nstate = EX2;
                    oe_n = sel(dst_q);
                    ie_n = sel(src_q);
                end
`endif
            end
`ifdef RF_CTRL_SWAP_EN
            EX2: begin
                nstate = EX3;
                d_n = tmp;
                den_n = 1'b1;
                ie_n = sel(dst_q);
            end
            EX3: nstate = FIN;
`endif
            FIN: nstate = IDLE;
            default: nstate = IDLE;
        endcase
        if (nstate == FIN && state != FIN) done_n[cown] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            d          <= '0;
            d_en       <= 1'b0;
            ie         <= '0;
            oe         <= '0;
            busy       <= 1'b0;
            done       <= '0;
            err        <= 1'b0;
            op_q       <= '0;
            src_q      <= '0;
            dst_q      <= '0;
            imm_q      <= '0;
            own_q      <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            state <= nstate;
            d     <= d_n;
            d_en  <= den_n;
            ie    <= ie_n;
            oe    <= oe_n;
            busy  <= (nstate != IDLE);
            done  <= done_n;
            err   <= err_n;
            if (take) begin
                op_q       <= cop;
                src_q      <= csrc;
                dst_q      <= cdst;
                imm_q      <= cimm;
                own_q      <= cown;
                last_grant <= cown;
            end
        end
    end

`ifdef RF_CTRL_SWAP_EN
    // The register file shows oe[src] on bus_in during EX1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) tmp <= '0;
        else if (state == EX1 && op_q == OP_SWP) tmp <= bus_in;
    end
`endif
endmodule

// File: doc/rf_ctrl.md
# rf_ctrl

Sequencer and two-port arbiter for the 8-bit register file (A, B, C, D, F). It accepts register-transfer commands from two requesters (port 0: instruction decoder, port 1: debug/load port) over valid/ready handshakes. Each command is executed as a cycle-exact sequence of one-hot load-enable / output-enable strobes, with the controller's own bus drive where needed. At most one source ever drives the shared 8-bit bus in any cycle.

## Interface
- No parameters; data width fixed at 8, register codes fixed at 3 bits.
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  2  per-requester command valid, bit i = port i
- req_ready  out  2  per-requester accept; a command is taken when valid & ready are both high at a rising edge
- req_op  in  4  {op1, op0}, 2 bits per port: 00 NOP, 01 MOV, 10 LDI, 11 SWP
- req_src  in  6  {src1, src0}, 3-bit register code: 0 A, 1 B, 2 C, 3 D, 4 F, 5–7 invalid
- req_dst  in  6  {dst1, dst0}, same encoding
- req_imm  in  16  {imm1, imm0}, LDI immediate
- bus_in  in  8  register-file bus output (rf `p`)
- d  out  8  controller bus drive value, 0 when not driving
- d_en  out  1  controller is driving `d` onto the bus
- ie  out  5  one-hot load enables {F, D, C, B, A}
- oe  out  5  one-hot output enables {F, D, C, B, A}
- busy  out  1  command in execution (state ≠ IDLE)
- done  out  2  one-cycle completion pulse to the owning port
- err  out  1  one-cycle pulse, coincident with `done`, for a rejected command

## Operation
- States: IDLE, EX1, EX2, EX3, FIN. All outputs registered except `req_ready`.
- Arbitration in IDLE: a single valid port wins. When both are valid, the port not granted last wins (round robin). `last_grant` resets to 1, so port 0 wins first. `req_ready` is high only for the winner, and only in IDLE.
- On accept, latch op/src/dst/imm and the owner id. Record the owner as `last_grant`.
- NOP: IDLE → FIN, no strobes.
- MOV: EX1 with oe[src]=1 and ie[dst]=1, then FIN. If src == dst, treat as NOP.
- LDI: EX1 with d=imm, d_en=1, ie[dst]=1, then FIN. `src` is ignored.
- SWP: three cycles.
  - EX1: oe[src]=1; capture bus_in into `tmp`.
  - EX2: oe[dst]=1, ie[src]=1.
  - EX3: d=tmp, d_en=1, ie[dst]=1.
  - Then FIN. If src == dst, treat as NOP.
- Invalid register code in any field the op uses: IDLE → FIN, no strobes, err=1 in FIN.
- FIN: done[owner]=1 for one cycle, then IDLE. Arbitration runs again on the following cycle.
- Invariants:
  - `oe` is at most one-hot.
  - `d_en` and any `oe` bit are never both high.
  - `ie` is at most one-hot.
  - Every strobe is high for exactly one cycle per use.
- `req_*` changes while busy are ignored.

## Timing
- Reset values: state IDLE, d=0, d_en=0, ie=0, oe=0, busy=0, done=0, err=0, tmp=0, last_grant=1. `req_ready` follows IDLE arbitration immediately after reset release.
- Reset asserted mid-command: all strobes drop asynchronously, the command is aborted, no `done` is issued.
- Cycle counts, with accept at edge k:
  - MOV/LDI: strobes in cycle k..k+1; register file loads at edge k+1; done in cycle k+1..k+2.
  - SWP: strobes over cycles k..k+3; done in cycle k+3..k+4.
  - NOP/err: done in cycle k..k+1.
- Back-to-back commands: the next accept is at earliest the edge ending the FIN cycle + 1, i.e. one command in flight.
- `tmp` captures bus_in at the edge ending EX1. The register file must present the selected register on `p` combinationally from `oe` within that cycle.

## Configuration
- `RF_CTRL_SWAP_EN` defined: SWP is implemented as above; states EX2/EX3 and `tmp` exist.
- `RF_CTRL_SWAP_EN` undefined:
  - SWP is illegal: IDLE → FIN with err=1 and no strobes.
  - EX2, EX3 and `tmp` are not built.
  - All other ops behave identically.

## Test plan
- Reset, then port 0 LDI A,100 → ie=00001, d=100, d_en=1 for one cycle; done=01 next cycle; rf A reads 100.
- MOV A→B after the LDI → oe=00001, ie=00010 in the same single cycle, d_en=0; B reads 100; done=01.
- Both ports valid continuously with LDI C,64 (port 0) and LDI D,4 (port 1) → grants alternate 0,1,0,1; each done lands on the correct port.
- SWP A,C with A=100, C=64 (macro defined):
  - EX1 oe=A, tmp=100.
  - EX2 oe=C, ie=A.
  - EX3 d=100, ie=C.
  - Final state A=64, C=100.
  - With the macro undefined, the same command gives err=1, no strobes, registers unchanged.
- MOV with src=5 → err=1 and done in the cycle after accept, ie=oe=0 throughout.
- rst driven low during SWP EX2 → ie, oe, d_en and busy go 0 with no clock edge; no done; port 0 accepted again after release.
